// File: rtl/instr_mem_pkg.sv
// Shared types and sizing helpers for the instruction-memory arbiter slice.
package instr_mem_pkg;

  typedef enum logic {
    MST_CORE,
    MST_DBG
  } master_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_ERR
  } arb_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES_DEF) + 1;

  // Timer width for an arbitrary watchdog length (module parameters cannot reach the package).
  function automatic int unsigned timer_width(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles) + 1;
  endfunction

endpackage

// File: rtl/instr_mem_arbiter_if.sv
// Bundles the fetch port, loader port and RAM port seen by instr_mem_arbiter.
interface instr_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                      instr_req_i;
  logic [ADDR_WIDTH-1:0]     instr_addr_i;
  logic                      instr_gnt_o;
  logic                      instr_rvalid_o;
  logic [DATA_WIDTH-1:0]     instr_rdata_o;
  logic                      instr_err_o;

  logic                      dbg_req_i;
  logic                      dbg_we_i;
  logic [DATA_WIDTH/8-1:0]   dbg_be_i;
  logic [ADDR_WIDTH-1:0]     dbg_addr_i;
  logic [DATA_WIDTH-1:0]     dbg_wdata_i;
  logic                      dbg_gnt_o;
  logic                      dbg_rvalid_o;
  logic [DATA_WIDTH-1:0]     dbg_rdata_o;
  logic                      dbg_err_o;

  logic                      mem_en_o;
  logic [ADDR_WIDTH-1:0]     mem_addr_o;
  logic [DATA_WIDTH-1:0]     mem_wdata_o;
  logic                      mem_we_o;
  logic [DATA_WIDTH/8-1:0]   mem_be_o;
  logic [DATA_WIDTH-1:0]     mem_rdata_i;
  logic                      mem_rvalid_i;
  logic                      stray_rvalid_o;

  // Arbiter side.
  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  dbg_req_i, dbg_we_i, dbg_be_i, dbg_addr_i, dbg_wdata_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o,
    output mem_en_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o,
    input  mem_rdata_i, mem_rvalid_i,
    output stray_rvalid_o
  );

  // Masters and RAM side.
  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output dbg_req_i, dbg_we_i, dbg_be_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o,
    input  mem_en_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o,
    output mem_rdata_i, mem_rvalid_i,
    input  stray_rvalid_o
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin picker; rr_last advances only on an enabled grant.
module rr_arb2
  import instr_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_core_i,
  input  logic req_dbg_i,
  output logic gnt_core_o,
  output logic gnt_dbg_o
);

  master_e rr_last_q;

  always_comb begin
    gnt_core_o = 1'b0;
    gnt_dbg_o  = 1'b0;
    if (en_i) begin
      if (req_core_i && req_dbg_i) begin
        gnt_core_o = (rr_last_q == MST_DBG);
        gnt_dbg_o  = (rr_last_q == MST_CORE);
      end else begin
        gnt_core_o = req_core_i;
        gnt_dbg_o  = req_dbg_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= MST_DBG;
    end else if (gnt_core_o) begin
      rr_last_q <= MST_CORE;
    end else if (gnt_dbg_o) begin
      rr_last_q <= MST_DBG;
    end
  end

endmodule

// File: rtl/instr_mem_arbiter.sv
// Owns the instruction RAM port: arbitrates fetch vs loader, routes the single
// outstanding response to its owner and times out missing responses.
module instr_mem_arbiter
  import instr_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 17,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic          clk,
  input logic          rst_n,
  instr_mem_arbiter_if.slave bus
);

  localparam int unsigned TimerW = timer_width(TIMEOUT_CYCLES);
  localparam int unsigned BeW    = DATA_WIDTH / 8;

  arb_state_e            state_q, state_d;
  master_e               owner_q, owner_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic                  stray_q, stray_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [BeW-1:0]        be_q, be_d;

  logic issue_win, gnt_core, gnt_dbg, gnt_any;
  logic resp_ok, resp_err;

  // Grants are suppressed while reset is asserted, even though the state reads IDLE.
  assign issue_win = rst_n &&
                     ((state_q == ARB_IDLE) || ((state_q == ARB_WAIT) && bus.mem_rvalid_i));
  assign gnt_any   = gnt_core | gnt_dbg;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (issue_win),
    .req_core_i (bus.instr_req_i),
    .req_dbg_i  (bus.dbg_req_i),
    .gnt_core_o (gnt_core),
    .gnt_dbg_o  (gnt_dbg)
  );

  assign bus.instr_gnt_o = gnt_core;
  assign bus.dbg_gnt_o   = gnt_dbg;

  // RAM request: driven from the winner on a grant, otherwise holds the last issue.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    be_d    = be_q;
    if (gnt_core) begin
      addr_d = bus.instr_addr_i;
      we_d   = 1'b0;
      be_d   = '1;
    end else if (gnt_dbg) begin
      addr_d  = bus.dbg_addr_i;
      wdata_d = bus.dbg_wdata_i;
      we_d    = bus.dbg_we_i;
      be_d    = bus.dbg_be_i;
    end
  end

  assign bus.mem_en_o    = gnt_any;
  assign bus.mem_addr_o  = addr_d;
  assign bus.mem_wdata_o = wdata_d;
  assign bus.mem_we_o    = we_d;
  assign bus.mem_be_o    = be_d;

  assign resp_ok  = (state_q == ARB_WAIT) && bus.mem_rvalid_i;
  assign resp_err = (state_q == ARB_ERR);

  always_comb begin
    bus.instr_rvalid_o = 1'b0;
    bus.instr_rdata_o  = '0;
    bus.instr_err_o    = 1'b0;
    bus.dbg_rvalid_o   = 1'b0;
    bus.dbg_rdata_o    = '0;
    bus.dbg_err_o      = 1'b0;
    if (resp_ok || resp_err) begin
      if (owner_q == MST_CORE) begin
        bus.instr_rvalid_o = 1'b1;
        bus.instr_err_o    = resp_err;
        bus.instr_rdata_o  = resp_ok ? bus.mem_rdata_i : '0;
      end else begin
        bus.dbg_rvalid_o = 1'b1;
        bus.dbg_err_o    = resp_err;
        bus.dbg_rdata_o  = resp_ok ? bus.mem_rdata_i : '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    timer_d = timer_q;
    stray_d = stray_q | (bus.mem_rvalid_i && (state_q != ARB_WAIT));
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_any) begin
          state_d = ARB_WAIT;
          owner_d = gnt_core ? MST_CORE : MST_DBG;
          timer_d = '0;
        end
      end
      ARB_WAIT: begin
        if (bus.mem_rvalid_i) begin
          if (gnt_any) begin
            owner_d = gnt_core ? MST_CORE : MST_DBG;
            timer_d = '0;
          end else begin
            state_d = ARB_IDLE;
          end
        end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ARB_ERR;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      ARB_ERR: state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.stray_rvalid_o = stray_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= MST_CORE;
      timer_q <= '0;
      stray_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      timer_q <= timer_d;
      stray_q <= stray_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter; responses are checked by a queue-based monitor.
module tb_instr_mem_arbiter;
  import instr_mem_pkg::*;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_mem_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    master_e     mst;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  function automatic void push(input master_e mst, input logic [31:0] data, input logic err);
    exp_t e;
    e.mst  = mst;
    e.data = data;
    e.err  = err;
    exp_q.push_back(e);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Response monitor.
  exp_t    got_e;
  master_e got_m;
  always @(negedge clk) begin
    if (bus.instr_rvalid_o && bus.dbg_rvalid_o) begin
      check("both_rvalid", 32'd1, 32'd0);
    end else if (bus.instr_rvalid_o || bus.dbg_rvalid_o) begin
      got_m = bus.dbg_rvalid_o ? MST_DBG : MST_CORE;
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'(got_m) + 32'd1, 32'd0);
      end else begin
        got_e = exp_q.pop_front();
        check("resp_owner", 32'(got_m), 32'(got_e.mst));
        if (got_m == MST_CORE) begin
          check("resp_rdata", bus.instr_rdata_o, got_e.data);
          check("resp_err", 32'(bus.instr_err_o), 32'(got_e.err));
          check("nonowner_quiet", {bus.dbg_rdata_o[30:0], bus.dbg_err_o}, 32'd0);
        end else begin
          check("resp_rdata", bus.dbg_rdata_o, got_e.data);
          check("resp_err", 32'(bus.dbg_err_o), 32'(got_e.err));
          check("nonowner_quiet", {bus.instr_rdata_o[30:0], bus.instr_err_o}, 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = '0;
    bus.dbg_req_i    = 1'b1;
    bus.dbg_we_i     = 1'b0;
    bus.dbg_be_i     = '0;
    bus.dbg_addr_i   = '0;
    bus.dbg_wdata_i  = '0;
    bus.mem_rdata_i  = '0;
    bus.mem_rvalid_i = 1'b0;

    // Reset: requests present but nothing may be granted.
    mid();
    check("rst_instr_gnt", 32'(bus.instr_gnt_o), 32'd0);
    check("rst_dbg_gnt", 32'(bus.dbg_gnt_o), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en_o), 32'd0);
    check("rst_stray", 32'(bus.stray_rvalid_o), 32'd0);
    bus.instr_req_i = 1'b0;
    bus.dbg_req_i   = 1'b0;
    next_cycle();
    rst_n = 1'b1;

    // Both masters requesting: core, dbg, core, dbg at one access per cycle.
    bus.instr_addr_i = 17'h00200;
    bus.dbg_addr_i   = 17'h00300;
    bus.dbg_be_i     = 4'hF;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus.instr_req_i  = 1'b1;
      bus.dbg_req_i    = 1'b1;
      bus.mem_rvalid_i = (i > 0);
      bus.mem_rdata_i  = 32'hA000_0000 + 32'(i) - 32'd1;
      push((i % 2 == 0) ? MST_CORE : MST_DBG, 32'hA000_0000 + 32'(i), 1'b0);
      mid();
      check("rr_instr_gnt", 32'(bus.instr_gnt_o), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_dbg_gnt", 32'(bus.dbg_gnt_o), (i % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_mem_en", 32'(bus.mem_en_o), 32'd1);
      check("rr_mem_addr", 32'(bus.mem_addr_o), (i % 2 == 0) ? 32'h200 : 32'h300);
    end
    next_cycle();
    bus.instr_req_i  = 1'b0;
    bus.dbg_req_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hA000_0003;
    mid();
    check("rr_tail_mem_en", 32'(bus.mem_en_o), 32'd0);
    next_cycle();
    bus.mem_rvalid_i = 1'b0;

    // Core-only fetch, RAM answers one cycle later.
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 17'h00100;
    push(MST_CORE, 32'hDEAD_BEEF, 1'b0);
    mid();
    check("fetch_gnt", 32'(bus.instr_gnt_o), 32'd1);
    check("fetch_mem_en", 32'(bus.mem_en_o), 32'd1);
    check("fetch_mem_addr", 32'(bus.mem_addr_o), 32'h100);
    check("fetch_mem_we", 32'(bus.mem_we_o), 32'd0);
    check("fetch_mem_be", 32'(bus.mem_be_o), 32'hF);
    next_cycle();
    bus.instr_req_i  = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hDEAD_BEEF;
    mid();
    check("fetch_dbg_rvalid", 32'(bus.dbg_rvalid_o), 32'd0);
    check("hold_mem_addr", 32'(bus.mem_addr_o), 32'h100);
    next_cycle();
    bus.mem_rvalid_i = 1'b0;

    // Loader write.
    bus.dbg_req_i   = 1'b1;
    bus.dbg_we_i    = 1'b1;
    bus.dbg_be_i    = 4'h3;
    bus.dbg_addr_i  = 17'h10040;
    bus.dbg_wdata_i = 32'h0000_A5A5;
    push(MST_DBG, 32'h0BAD_0000, 1'b0);
    mid();
    check("wr_gnt", 32'(bus.dbg_gnt_o), 32'd1);
    check("wr_mem_we", 32'(bus.mem_we_o), 32'd1);
    check("wr_mem_be", 32'(bus.mem_be_o), 32'h3);
    check("wr_mem_addr", 32'(bus.mem_addr_o), 32'h10040);
    check("wr_mem_wdata", bus.mem_wdata_o, 32'h0000_A5A5);
    next_cycle();
    bus.dbg_req_i    = 1'b0;
    bus.dbg_we_i     = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0BAD_0000;
    mid();
    next_cycle();
    bus.mem_rvalid_i = 1'b0;

    // Three-cycle latency with a loader read pending.
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 17'h00400;
    push(MST_CORE, 32'hC0DE_0003, 1'b0);
    mid();
    check("lat_core_gnt", 32'(bus.instr_gnt_o), 32'd1);
    next_cycle();
    bus.instr_req_i = 1'b0;
    bus.dbg_req_i   = 1'b1;
    bus.dbg_be_i    = 4'hF;
    bus.dbg_addr_i  = 17'h00500;
    for (int k = 1; k < 3; k++) begin
      mid();
      check("lat_dbg_blocked", {bus.dbg_gnt_o, bus.mem_en_o}, 32'd0);
      next_cycle();
    end
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hC0DE_0003;
    push(MST_DBG, 32'h5A5A_0005, 1'b0);
    mid();
    check("lat_dbg_gnt", 32'(bus.dbg_gnt_o), 32'd1);
    check("lat_mem_addr", 32'(bus.mem_addr_o), 32'h500);
    next_cycle();
    bus.dbg_req_i   = 1'b0;
    bus.mem_rdata_i = 32'h5A5A_0005;
    mid();
    next_cycle();
    bus.mem_rvalid_i = 1'b0;

    // Timeout: TO wait cycles, then a one-cycle error with no grant.
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 17'h00600;
    push(MST_CORE, 32'h0, 1'b1);
    mid();
    check("to_gnt", 32'(bus.instr_gnt_o), 32'd1);
    next_cycle();
    bus.instr_req_i = 1'b0;
    bus.dbg_req_i   = 1'b1;
    bus.dbg_addr_i  = 17'h00604;
    for (int k = 1; k <= int'(TO); k++) begin
      mid();
      check("to_wait_no_err", {bus.dbg_gnt_o, bus.instr_err_o}, 32'd0);
      next_cycle();
    end
    mid();
    check("to_err", 32'(bus.instr_err_o), 32'd1);
    check("to_err_no_gnt", {bus.dbg_gnt_o, bus.mem_en_o}, 32'd0);
    next_cycle();
    push(MST_DBG, 32'h7777_0007, 1'b0);
    mid();
    check("to_after_gnt", 32'(bus.dbg_gnt_o), 32'd1);
    check("to_after_addr", 32'(bus.mem_addr_o), 32'h604);
    next_cycle();
    bus.dbg_req_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h7777_0007;
    mid();
    check("stray_clear", 32'(bus.stray_rvalid_o), 32'd0);
    next_cycle();
    bus.mem_rdata_i = 32'h0000_0BAD;
    mid();
    next_cycle();
    bus.mem_rvalid_i = 1'b0;
    mid();
    check("stray_set", 32'(bus.stray_rvalid_o), 32'd1);

    // Reset in the middle of an access, then a late RAM response.
    next_cycle();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 17'h00700;
    mid();
    check("rst_mid_gnt", 32'(bus.instr_gnt_o), 32'd1);
    next_cycle();
    bus.instr_req_i = 1'b0;
    #2;
    rst_n = 1'b0;
    mid();
    check("rst_mid_stray", 32'(bus.stray_rvalid_o), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0000_5555;
    mid();
    next_cycle();
    bus.mem_rvalid_i = 1'b0;
    mid();
    check("late_stray", 32'(bus.stray_rvalid_o), 32'd1);
    next_cycle();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 17'h00800;
    push(MST_CORE, 32'h1234_5678, 1'b0);
    mid();
    check("post_rst_gnt", 32'(bus.instr_gnt_o), 32'd1);
    next_cycle();
    bus.instr_req_i  = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h1234_5678;
    mid();
    next_cycle();
    bus.mem_rvalid_i = 1'b0;
    mid();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
